vrf_write_arbiter: RTL

//  Shares the single vector register file write port (we3/wa3/wd3) between NREQ writeback sources
//  (port 0 = vector ALU, port 1 = vector load unit, spares for future units). Round-robin valid/ready

---
 rtl/vrf_write_arbiter_pkg.sv | 22 ++
 rtl/vrf_rr_arbiter.sv | 43 ++++
 rtl/vrf_write_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/vrf_write_arbiter_pkg.sv
// Shared definitions for the vector register file writeback path.
package vrf_pkg;

  localparam int VRF_DATA_WIDTH   = 8;
  localparam int VRF_VECTOR_SIZE  = 8;
  localparam int VRF_ADDRESSWIDTH = 4;
  localparam int VRF_NREQ         = 2;
  localparam int VRF_WAITCNT_W    = 16;

  // Fixed requester slots; higher indices are spares for future units.
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;

  typedef logic [VRF_VECTOR_SIZE-1:0][VRF_DATA_WIDTH-1:0] vec_t;
  typedef logic [VRF_ADDRESSWIDTH-1:0]                    vaddr_t;

  // Round-robin successor of slot g among n requesters.
  function automatic int rr_next(input int g, input int n);
    return (g + 1) % n;
  endfunction

endpackage

// File: rtl/vrf_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered priority pointer.
module vrf_rr_arbiter
  import vrf_pkg::*;
#(
  parameter int NREQ = VRF_NREQ
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold_i,
  input  logic [NREQ-1:0] req_valid_i,
  output logic [NREQ-1:0] grant_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  // Scan from the far end back to rr_ptr so the slot closest to rr_ptr wins last.
  // No grant while held or while reset is asserted.
  always_comb begin
    int idx;
    idx      = 0;
    grant_o  = '0;
    rr_ptr_d = rr_ptr_q;
    if (rst_n && !hold_i) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        idx = (int'(rr_ptr_q) + k) % NREQ;
        if (req_valid_i[idx]) begin
          grant_o      = '0;
          grant_o[idx] = 1'b1;
          rr_ptr_d     = PW'(rr_next(idx, NREQ));
        end
      end
    end
  end

  // Priority pointer advances past the winner; frozen when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/vrf_write_arbiter.sv
// Vector register file write-port arbiter with registered output stage,
// saturating contention counter and optional read-after-write forwarding.
// Build option: define VRF_WB_BYPASS_EN to forward the in-flight write to
// the read ports; otherwise fwd_rd1/2 pass rf_rd1/2 straight through.
module vrf_write_arbiter
  import vrf_pkg::*;
#(
  parameter int DATA_WIDTH   = VRF_DATA_WIDTH,
  parameter int VECTOR_SIZE  = VRF_VECTOR_SIZE,
  parameter int ADDRESSWIDTH = VRF_ADDRESSWIDTH,
  parameter int NREQ         = VRF_NREQ,
  parameter int WAITCNT_W    = VRF_WAITCNT_W
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             hold,
  input  logic [NREQ-1:0]                                  req_valid,
  input  logic [NREQ-1:0][ADDRESSWIDTH-1:0]                req_addr,
  input  logic [NREQ-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]                                  req_ready,
  output logic                                             we3,
  output logic [ADDRESSWIDTH-1:0]                          wa3,
  output logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]           wd3,
  input  logic [ADDRESSWIDTH-1:0]                          ra1,
  input  logic [ADDRESSWIDTH-1:0]                          ra2,
  input  logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]           rf_rd1,
  input  logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]           rf_rd2,
  output logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]           fwd_rd1,
  output logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]           fwd_rd2,
  output logic [WAITCNT_W-1:0]                             wait_cnt
);

  logic [NREQ-1:0]                        grant;
  logic                                   any_grant;
  logic                                   multi_vld;
  logic                                   wait_inc;
  logic [ADDRESSWIDTH-1:0]                sel_addr;
  logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] sel_data;

  logic                                   we3_q;
  logic [ADDRESSWIDTH-1:0]                wa3_q;
  logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] wd3_q;
  logic [WAITCNT_W-1:0]                   wait_cnt_q;

  vrf_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold_i      (hold),
    .req_valid_i (req_valid),
    .grant_o     (grant)
  );

  assign req_ready = grant;
  assign any_grant = |grant;
  assign multi_vld = $countones(req_valid) > 1;
  // A cycle counts as waiting if someone valid was left without a grant.
  assign wait_inc  = (|req_valid) & (~any_grant | multi_vld);

  // Winner's address/data mux (grant is one-hot or zero).
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i];
        sel_data = req_data[i];
      end
    end
  end

  // Output stage: one write per granted cycle; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3_q <= 1'b0;
      wa3_q <= '0;
      wd3_q <= '0;
    end else begin
      we3_q <= any_grant;
      if (any_grant) begin
        wa3_q <= sel_addr;
        wd3_q <= sel_data;
      end
    end
  end

  // Saturating contention counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 wait_cnt_q <= '0;
    else if (wait_inc && (wait_cnt_q != '1))    wait_cnt_q <= wait_cnt_q + 1'b1;
  end

  assign we3      = we3_q;
  assign wa3      = wa3_q;
  assign wd3      = wd3_q;
  assign wait_cnt = wait_cnt_q;

`ifdef VRF_WB_BYPASS_EN
  // The write in the output stage lands at the end of this cycle; forward it.
  assign fwd_rd1 = (we3_q && (ra1 == wa3_q)) ? wd3_q : rf_rd1;
  assign fwd_rd2 = (we3_q && (ra2 == wa3_q)) ? wd3_q : rf_rd2;
`else
  // Decode stalls on RAW against wa3 instead, so read data passes through.
  logic unused_ra;
  assign unused_ra = ^{ra1, ra2};
  assign fwd_rd1   = rf_rd1;
  assign fwd_rd2   = rf_rd2;
`endif

endmodule
